board_input_conditioner: RTL and testbench
==========================================

# board_input_conditioner

Board-side input front end for the Nios II system. It synchronises and debounces the raw push-buttons (active-low keys) and slide switches before they drive the processor's button and switch PIO inputs. It also produces single-cycle press pulses for the buttons. It runs in the same clock domain as the processor system and sits between the FPGA pins and the button/switch PIO export ports.

## Interface
Parameters:
- NUM_BUTTONS, 4, number of push-buttons
- NUM_SWITCHES, 10, number of slide switches
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before an output changes (10 ms at 50 MHz); minimum 2

Ports:
- clk_clk  input  1  system clock
- reset_reset_n  input  1  asynchronous, active-low reset
- key_n_raw  input  NUM_BUTTONS  raw button pins, 0 = pressed, asynchronous
- sw_raw  input  NUM_SWITCHES  raw switch pins, asynchronous
- button_state  output  NUM_BUTTONS  debounced, active-high (1 = pressed); drives button PIO
- button_press  output  NUM_BUTTONS  one-cycle pulse on each debounced press
- switch_state  output  NUM_SWITCHES  debounced switch level; drives switch PIO
- edge_clear  input  NUM_BUTTONS  write-1-to-clear for edge_flags
- edge_flags  output  NUM_BUTTONS  sticky press flags

Clock and reset: one clock, clk_clk. Reset is asynchronous and active-low, on reset_reset_n.

## Operation
- Every raw input goes through a two-flop synchroniser.
  - Button synchronisers reset to 1 (released).
  - Switch synchronisers reset to 0.
- Each button and each switch has its own debounce channel: a registered stable level plus a down-counter of width clog2(DEBOUNCE_CYCLES+1).
- Button channel FSM: RELEASED -> CONFIRM_PRESS -> PRESSED -> CONFIRM_RELEASE -> RELEASED.
  - RELEASED: synced input 0 → load counter with DEBOUNCE_CYCLES-1, go to CONFIRM_PRESS.
  - CONFIRM_PRESS: input returns to 1 → back to RELEASED, counter discarded. Counter reaches 0 with input still 0 → PRESSED; button_state goes to 1 and button_press pulses for exactly one cycle.
  - PRESSED / CONFIRM_RELEASE: symmetric. No pulse on release.
- Switch channel: the same two-confirm scheme without a pulse. switch_state follows the synced level once it has been stable for DEBOUNCE_CYCLES cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles never reaches any output. Every glitch restarts the confirmation from full count.
- Channels are fully independent. Simultaneous presses on several buttons each produce their own pulse in the same cycle.
- Reset asserted mid-confirmation: all FSMs return to RELEASED (or the switch idle state), counters are cleared, and all outputs return to their reset values immediately (asynchronously).

## Timing
- Reset values: button_state = 0, button_press = 0, switch_state = 0, edge_flags = 0.
- Latency from a clean raw edge to an output change: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles + 1 register cycle, exact to ±1 cycle of synchroniser sampling.
- button_press is asserted in the same cycle in which button_state rises, for 1 cycle.
- Switches held at 1 through reset: switch_state rises DEBOUNCE_CYCLES+3 cycles after reset release. No spurious button pulse occurs after reset.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration
- Macro: BUTTON_EDGE_CAPTURE_EN.
- Defined:
  - edge_flags[i] sets in the cycle after button_press[i].
  - edge_flags[i] clears in the cycle after edge_clear[i] = 1.
  - Set and clear in the same cycle: set wins, flag stays 1.
- Undefined:
  - edge_flags is constant 0.
  - edge_clear is ignored.
  - The ports remain so the top-level port list is unchanged.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 8.
1. Reset with all keys released and sw_raw = 10'h000, then hold for 50 cycles → all outputs remain 0, no button_press pulses.
2. key_n_raw[0] driven low and held → button_state[0] = 1 at 11 ±1 cycles after the edge; button_press[0] high for exactly 1 cycle. Release → button_state[0] = 0 after the same latency, no pulse.
3. key_n_raw[1] bounces (low 3 cycles, high 2, low 4, high) → button_state[1] and button_press[1] stay 0 throughout.
4. key_n_raw[3:0] = 4'b0000 in the same cycle → button_press = 4'hF in a single cycle. With BUTTON_EDGE_CAPTURE_EN: edge_flags = 4'hF next cycle. Then edge_clear = 4'h5 → edge_flags = 4'hA. A new press on button 0 coinciding with edge_clear[0] → edge_flags[0] stays 1.
5. sw_raw = 10'h2A5 → switch_state = 10'h2A5 after 11 ±1 cycles. Then a 5-cycle glitch on sw_raw[9] → switch_state unchanged.
6. Button 2 in CONFIRM_PRESS (4 cycles into the count), reset_reset_n pulsed low → all outputs 0 immediately. After release with the key still held, a fresh full-latency press is detected with exactly one button_press[2] pulse.

Source files
------------

// File: rtl/board_input_conditioner.sv
// board_input_conditioner
// Synchronises and debounces raw push-buttons (active-low) and slide switches
// for the Nios II button/switch PIOs, and generates one-cycle press pulses.
// Optional sticky press flags are enabled by defining BUTTON_EDGE_CAPTURE_EN;
// without it edge_flags is tied to 0 and edge_clear is ignored.
module board_input_conditioner #(
  parameter int NUM_BUTTONS     = 4,
  parameter int NUM_SWITCHES    = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NUM_BUTTONS-1:0]  key_n_raw,
  input  logic [NUM_SWITCHES-1:0] sw_raw,
  output logic [NUM_BUTTONS-1:0]  button_state,
  output logic [NUM_BUTTONS-1:0]  button_press,
  output logic [NUM_SWITCHES-1:0] switch_state,
  input  logic [NUM_BUTTONS-1:0]  edge_clear,
  output logic [NUM_BUTTONS-1:0]  edge_flags
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LOAD_VAL = CW'(DEBOUNCE_CYCLES - 1);

  // Shared encoding: button RELEASED/CONFIRM_PRESS/PRESSED/CONFIRM_RELEASE,
  // switch LOW/CONFIRM_HIGH/HIGH/CONFIRM_LOW.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONF_ON = 2'd1;
  localparam logic [1:0] ST_ON      = 2'd2;
  localparam logic [1:0] ST_CONF_OFF = 2'd3;

  logic [NUM_BUTTONS-1:0]  r_key_meta;
  logic [NUM_BUTTONS-1:0]  r_key_sync;
  logic [NUM_SWITCHES-1:0] r_sw_meta;
  logic [NUM_SWITCHES-1:0] r_sw_sync;

  // Two-flop synchronisers; keys idle at 1 (released), switches at 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_key_meta <= '1;
      r_key_sync <= '1;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_key_meta <= key_n_raw;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= sw_raw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  genvar gi;

  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      logic          w_pressed;
      logic [1:0]    r_fsm;
      logic [CW-1:0] r_cnt;
      logic          r_state;
      logic          r_press;

      assign w_pressed        = ~r_key_sync[gi];
      assign button_state[gi] = r_state;
      assign button_press[gi] = r_press;

      // Button debounce FSM: a level change must hold for the full count;
      // any bounce returns to the previous stable state and discards the count.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_fsm   <= ST_IDLE;
          r_cnt   <= '0;
          r_state <= 1'b0;
          r_press <= 1'b0;
        end else begin
          r_press <= 1'b0;
          case (r_fsm)
            ST_IDLE: begin
              if (w_pressed) begin
                r_fsm <= ST_CONF_ON;
                r_cnt <= LOAD_VAL;
              end
            end
            ST_CONF_ON: begin
              if (!w_pressed) begin
                r_fsm <= ST_IDLE;
                r_cnt <= '0;
              end else if (r_cnt == '0) begin
                r_fsm   <= ST_ON;
                r_state <= 1'b1;
                r_press <= 1'b1;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            ST_ON: begin
              if (!w_pressed) begin
                r_fsm <= ST_CONF_OFF;
                r_cnt <= LOAD_VAL;
              end
            end
            ST_CONF_OFF: begin
              if (w_pressed) begin
                r_fsm <= ST_ON;
                r_cnt <= '0;
              end else if (r_cnt == '0) begin
                r_fsm   <= ST_IDLE;
                r_state <= 1'b0;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            default: begin
              r_fsm <= ST_IDLE;
              r_cnt <= '0;
            end
          endcase
        end
      end
    end

    for (gi = 0; gi < NUM_SWITCHES; gi++) begin : g_sw
      logic          w_level;
      logic [1:0]    r_fsm;
      logic [CW-1:0] r_cnt;
      logic          r_state;

      assign w_level          = r_sw_sync[gi];
      assign switch_state[gi] = r_state;

      // Switch debounce FSM: same confirm scheme as the buttons, no pulse.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_fsm   <= ST_IDLE;
          r_cnt   <= '0;
          r_state <= 1'b0;
        end else begin
          case (r_fsm)
            ST_IDLE: begin
              if (w_level) begin
                r_fsm <= ST_CONF_ON;
                r_cnt <= LOAD_VAL;
              end
            end
            ST_CONF_ON: begin
              if (!w_level) begin
                r_fsm <= ST_IDLE;
                r_cnt <= '0;
              end else if (r_cnt == '0) begin
                r_fsm   <= ST_ON;
                r_state <= 1'b1;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            ST_ON: begin
              if (!w_level) begin
                r_fsm <= ST_CONF_OFF;
                r_cnt <= LOAD_VAL;
              end
            end
            ST_CONF_OFF: begin
              if (w_level) begin
                r_fsm <= ST_ON;
                r_cnt <= '0;
              end else if (r_cnt == '0) begin
                r_fsm   <= ST_IDLE;
                r_state <= 1'b0;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            default: begin
              r_fsm <= ST_IDLE;
              r_cnt <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

`ifdef BUTTON_EDGE_CAPTURE_EN
  logic [NUM_BUTTONS-1:0] r_edge_flags;

  assign edge_flags = r_edge_flags;

  // Sticky press flags: a press in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_edge_flags <= '0;
    end else begin
      r_edge_flags <= (r_edge_flags & ~edge_clear) | button_press;
    end
  end
`else
  logic [NUM_BUTTONS-1:0] w_unused_edge_clear;

  assign w_unused_edge_clear = edge_clear;
  assign edge_flags          = '0;
`endif

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed self-checking bench for board_input_conditioner (DEBOUNCE_CYCLES = 8).
// Expected edge_flags values follow BUTTON_EDGE_CAPTURE_EN when it is defined.
module tb_board_input_conditioner;

  localparam int NB = 4;
  localparam int NS = 10;
  localparam int D  = 8;
`ifdef BUTTON_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] key_n_raw;
  logic [NS-1:0] sw_raw;
  logic [NB-1:0] edge_clear;
  logic [NB-1:0] button_state;
  logic [NB-1:0] button_press;
  logic [NS-1:0] switch_state;
  logic [NB-1:0] edge_flags;

  int checks   = 0;
  int failures = 0;
  int press_cnt [NB];
  int cnt_before;

  board_input_conditioner #(
    .NUM_BUTTONS(NB),
    .NUM_SWITCHES(NS),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .key_n_raw(key_n_raw),
    .sw_raw(sw_raw),
    .button_state(button_state),
    .button_press(button_press),
    .switch_state(switch_state),
    .edge_clear(edge_clear),
    .edge_flags(edge_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NB; i++) press_cnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NB; i++)
      if (button_press[i] === 1'b1) press_cnt[i] = press_cnt[i] + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    key_n_raw  = 4'hF;
    sw_raw     = 10'h000;
    edge_clear = 4'h0;
    #23;
    check("rst_btn_state", 32'(button_state), 32'h0);
    check("rst_switch", 32'(switch_state), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: idle after reset
    step(50);
    check("idle_btn_state", 32'(button_state), 32'h0);
    check("idle_press", 32'(button_press), 32'h0);
    check("idle_switch", 32'(switch_state), 32'h0);
    check("idle_flags", 32'(edge_flags), 32'h0);
    check("idle_press_cnt", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'h0);

    // 2: clean press / release on button 0
    key_n_raw[0] = 1'b0;
    step(10);
    check("b0_press_lat10", 32'(button_state), 32'h0);
    step(1);
    check("b0_press_lat11_state", 32'(button_state), 32'h1);
    check("b0_press_lat11_pulse", 32'(button_press), 32'h1);
    step(1);
    check("b0_pulse_gone", 32'(button_press), 32'h0);
    check("b0_flag_set", 32'(edge_flags), EDGE_EN ? 32'h1 : 32'h0);
    edge_clear = 4'hF;
    step(1);
    edge_clear = 4'h0;
    check("b0_flag_clr", 32'(edge_flags), 32'h0);
    key_n_raw[0] = 1'b1;
    step(10);
    check("b0_rel_lat10", 32'(button_state), 32'h1);
    step(1);
    check("b0_rel_lat11", 32'(button_state), 32'h0);
    check("b0_rel_no_pulse", 32'(button_press), 32'h0);
    step(5);
    check("b0_press_cnt", 32'(press_cnt[0]), 32'd1);

    // 3: bouncing button 1 never passes
    key_n_raw[1] = 1'b0; step(3);
    key_n_raw[1] = 1'b1; step(2);
    key_n_raw[1] = 1'b0; step(4);
    key_n_raw[1] = 1'b1;
    step(20);
    check("b1_bounce_state", 32'(button_state), 32'h0);
    check("b1_bounce_cnt", 32'(press_cnt[1]), 32'd0);

    // 4: simultaneous presses and edge flags
    key_n_raw = 4'h0;
    step(11);
    check("all_press_pulse", 32'(button_press), 32'hF);
    check("all_press_state", 32'(button_state), 32'hF);
    step(1);
    check("all_press_pulse_gone", 32'(button_press), 32'h0);
    check("all_flags", 32'(edge_flags), EDGE_EN ? 32'hF : 32'h0);
    edge_clear = 4'h5;
    step(1);
    edge_clear = 4'h0;
    check("flags_clr5", 32'(edge_flags), EDGE_EN ? 32'hA : 32'h0);
    key_n_raw[0] = 1'b1;
    step(11);
    check("b0_rel_again", 32'(button_state), 32'hE);
    step(2);
    key_n_raw[0] = 1'b0;
    step(11);
    check("b0_repress_pulse", 32'(button_press), 32'h1);
    edge_clear = 4'h1;
    step(1);
    edge_clear = 4'h0;
    check("set_wins_flags", 32'(edge_flags), EDGE_EN ? 32'hB : 32'h0);
    step(1);
    check("set_wins_hold", 32'(edge_flags), EDGE_EN ? 32'hB : 32'h0);
    key_n_raw = 4'hF;
    step(15);
    check("all_released", 32'(button_state), 32'h0);
    check("cnt_b0", 32'(press_cnt[0]), 32'd3);
    check("cnt_b1", 32'(press_cnt[1]), 32'd1);
    check("cnt_b2", 32'(press_cnt[2]), 32'd1);
    check("cnt_b3", 32'(press_cnt[3]), 32'd1);

    // 5: switches and a short glitch
    sw_raw = 10'h2A5;
    step(10);
    check("sw_lat10", 32'(switch_state), 32'h0);
    step(1);
    check("sw_lat11", 32'(switch_state), 32'h2A5);
    sw_raw = 10'h0A5;
    step(5);
    sw_raw = 10'h2A5;
    check("sw_glitch_during", 32'(switch_state), 32'h2A5);
    step(15);
    check("sw_glitch_after", 32'(switch_state), 32'h2A5);

    // 6: reset in the middle of a press confirmation
    key_n_raw[2] = 1'b0;
    step(7);
    check("b2_confirming", 32'(button_state), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_btn", 32'(button_state), 32'h0);
    check("async_rst_sw", 32'(switch_state), 32'h0);
    check("async_rst_flags", 32'(edge_flags), 32'h0);
    check("async_rst_press", 32'(button_press), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_before = press_cnt[2];
    step(10);
    check("b2_after_rst_lat10", 32'(button_state), 32'h0);
    check("sw_after_rst_lat10", 32'(switch_state), 32'h0);
    step(1);
    check("b2_after_rst_lat11", 32'(button_state), 32'h4);
    check("b2_after_rst_pulse", 32'(button_press), 32'h4);
    check("sw_after_rst_lat11", 32'(switch_state), 32'h2A5);
    step(1);
    check("b2_after_rst_pulse_gone", 32'(button_press), 32'h0);
    step(5);
    check("b2_after_rst_cnt", 32'(press_cnt[2] - cnt_before), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
